// File: rtl/down_counter_pkg.sv
// Shared types and defaults for the down_counter block and its prescaler.
// Prescaler defaults matter only when DOWN_COUNTER_PRESCALE_EN is defined.
package down_counter_pkg;

    localparam int unsigned WIDTH_DEFAULT    = 6;
    localparam int unsigned PRESCALE_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01
    } state_t;

endpackage

// File: rtl/down_counter_prescaler.sv
// Divides en-qualified RUN cycles by PRESCALE; tick marks every PRESCALE-th one.
// Only instantiated by down_counter when DOWN_COUNTER_PRESCALE_EN is defined.
module down_counter_prescaler
    import down_counter_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned         CW   = $clog2(PRESCALE);
    localparam logic [CW-1:0]       LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;

    assign tick = en && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/down_counter.sv
// Loadable down counter / period timer with one-shot or auto-reload mode.
// Define DOWN_COUNTER_PRESCALE_EN to divide the decrement rate by PRESCALE.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEFAULT,
    parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    if (PRESCALE < 2 || PRESCALE > 256) begin : g_bad_prescale
        $error("down_counter: PRESCALE must lie in 2..256");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             r_tc;
    logic             w_tc_nxt;
    logic             w_tick;
    logic             w_start_ok;
    logic             w_terminal;

    // load outranks everything, so neither start nor the terminal action can fire with it
    assign w_start_ok = !load && start && (r_state == IDLE) && (r_count != '0);
    assign w_terminal = !load && (r_state == RUN) && w_tick && (r_count <= WIDTH'(1));

`ifdef DOWN_COUNTER_PRESCALE_EN
    logic w_pre_clr;
    logic w_pre_en;

    assign w_pre_clr = load | w_start_ok | w_terminal;
    assign w_pre_en  = en && (r_state == RUN);

    down_counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_pre_clr),
        .en   (w_pre_en),
        .tick (w_tick)
    );
`else
    assign w_tick = en;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_tc     <= w_tc_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;
        if (load) begin
            w_count_nxt  = load_val;
            w_reload_nxt = load_val;
            w_state_nxt  = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (w_terminal) begin
                        w_tc_nxt = 1'b1;
                        // auto_reload is only looked at here, so it may change freely mid-run
                        if (auto_reload && (r_reload != '0)) begin
                            w_count_nxt = r_reload;
                        end else begin
                            w_count_nxt = '0;
                            w_state_nxt = IDLE;
                        end
                    end else if (w_tick) begin
                        w_count_nxt = r_count - WIDTH'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign busy  = (r_state == RUN);

endmodule
